// File: rtl/dag_pkg.sv
// dag_pkg: shared constants and types for the data address generator.
// Optional wrap flag output is enabled by DAG_WRAP_FLAG_EN.
package dag_pkg;

  localparam int NUM_BUF = 8;
  localparam int ADDR_W  = 16;
  localparam int LEN_W   = 12;
  localparam int EXP_W   = 3;
  localparam int SEL_W   = $clog2(NUM_BUF);

  typedef logic [SEL_W-1:0] dag_sel_t;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic              sign;
    logic [EXP_W-1:0]  expt;
  } dag_cfg_t;

endpackage

// File: rtl/dag_next_off.sv
// dag_next_off: circular post-modify of a buffer offset by +/-2**expt.
// Flags when a wrap correction or a forced-zero recovery was applied.
module dag_next_off
  import dag_pkg::*;
(
  input  logic [LEN_W-1:0] offset,
  input  logic [LEN_W-1:0] len,
  input  logic             sign,
  input  logic [EXP_W-1:0] expt,
  output logic [LEN_W-1:0] next_off,
  output logic             wrapped
);

  localparam int TW = LEN_W + 2;

  logic signed [TW-1:0] step;
  logic signed [TW-1:0] lenx;
  logic signed [TW-1:0] offx;
  logic signed [TW-1:0] raw;
  logic signed [TW-1:0] fix;
  logic                 corr;
  logic                 bad;

  always_comb begin
    step = TW'(1) << expt;
    lenx = {2'b00, len};
    offx = {2'b00, offset};
    raw  = sign ? (offx - step) : (offx + step);
    corr = sign ? (raw < 0) : (raw >= lenx);
    fix  = raw;
    if (corr) fix = sign ? (raw + lenx) : (raw - lenx);
    // stride larger than the buffer can still land outside after one fix
    bad      = (fix < 0) || (fix >= lenx);
    next_off = bad ? '0 : fix[LEN_W-1:0];
    wrapped  = corr | bad;
  end

endmodule

// File: rtl/dag_core.sv
// dag_core: NUM_BUF circular-buffer address generator, registered output.
// Define DAG_WRAP_FLAG_EN to add the registered wrap output.
module dag_core
  import dag_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  dag_sel_t          cbs,
  input  logic              we,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic              sign,
  input  logic [EXP_W-1:0]  expt,
`ifdef DAG_WRAP_FLAG_EN
  output logic              wrap,
`endif
  output logic [ADDR_W-1:0] a
);

  dag_cfg_t         cfg [NUM_BUF];
  logic [LEN_W-1:0] off [NUM_BUF];

  dag_cfg_t         cur;
  logic [LEN_W-1:0] cur_off;
  logic [LEN_W-1:0] nxt_off;
  logic             nxt_wrap;

  assign cur     = cfg[cbs];
  assign cur_off = off[cbs];

  dag_next_off u_next (
    .offset   (cur_off),
    .len      (cur.len),
    .sign     (cur.sign),
    .expt     (cur.expt),
    .next_off (nxt_off),
    .wrapped  (nxt_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      a <= '0;
      for (int i = 0; i < NUM_BUF; i++) begin
        cfg[i] <= '0;
        off[i] <= '0;
      end
    end else if (we) begin
      cfg[cbs] <= '{base: base, len: len, sign: sign, expt: expt};
      off[cbs] <= '0;
    end else if (re) begin
      a        <= cur.base + ADDR_W'(cur_off);
      off[cbs] <= nxt_off;
    end
  end

`ifdef DAG_WRAP_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) wrap <= 1'b0;
    else       wrap <= re & ~we & nxt_wrap;
  end
`else
  logic unused_wrap;
  assign unused_wrap = nxt_wrap;
`endif

endmodule

// File: tb/tb_dag_core.sv
// tb_dag_core: directed and randomized checks of dag_core against
// an array-based reference model of the circular buffers.
module tb_dag_core;
  import dag_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              re = 1'b0;
  dag_sel_t          cbs = '0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] base = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              sign = 1'b0;
  logic [EXP_W-1:0]  expt = '0;
  logic [ADDR_W-1:0] a;
`ifdef DAG_WRAP_FLAG_EN
  logic              wrap;
`endif

  dag_core dut (
    .clk   (clk),
    .reset (reset),
    .re    (re),
    .cbs   (cbs),
    .we    (we),
    .base  (base),
    .len   (len),
    .sign  (sign),
    .expt  (expt),
`ifdef DAG_WRAP_FLAG_EN
    .wrap  (wrap),
`endif
    .a     (a)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_base [NUM_BUF];
  int m_len  [NUM_BUF];
  int m_sign [NUM_BUF];
  int m_exp  [NUM_BUF];
  int m_off  [NUM_BUF];
  int exp_a    = 0;
  int exp_wrap = 0;

  task automatic model_reset();
    for (int i = 0; i < NUM_BUF; i++) begin
      m_base[i] = 0; m_len[i] = 0; m_sign[i] = 0;
      m_exp[i] = 0;  m_off[i] = 0;
    end
    exp_a = 0;
    exp_wrap = 0;
  endtask

  task automatic model_read(input int b);
    int s, t, w;
    exp_a = (m_base[b] + m_off[b]) % 65536;
    s = 1 << m_exp[b];
    w = 0;
    if (m_sign[b] == 0) begin
      t = m_off[b] + s;
      if (t >= m_len[b]) begin t = t - m_len[b]; w = 1; end
    end else begin
      t = m_off[b] - s;
      if (t < 0) begin t = t + m_len[b]; w = 1; end
    end
    if (t < 0 || t >= m_len[b]) begin t = 0; w = 1; end
    m_off[b] = t;
    exp_wrap = w;
  endtask

  task automatic check(input string tag);
    checks++;
    assert (a === ADDR_W'(exp_a)) else begin
      errors++;
      $error("FAIL %s: a=%h expected %h", tag, a, ADDR_W'(exp_a));
    end
`ifdef DAG_WRAP_FLAG_EN
    checks++;
    assert (wrap === 1'(exp_wrap)) else begin
      errors++;
      $error("FAIL %s wrap: got %b expected %b", tag, wrap, 1'(exp_wrap));
    end
`endif
  endtask

  task automatic expect_a(input logic [ADDR_W-1:0] v, input string tag);
    checks++;
    assert (a === v) else begin
      errors++;
      $error("FAIL %s: a=%h expected %h", tag, a, v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int b, input int bs, input int ln,
                        input int sg, input int ex, input bit rd);
    cbs = dag_sel_t'(b); we = 1'b1; re = rd;
    base = ADDR_W'(bs); len = LEN_W'(ln); sign = sg[0]; expt = EXP_W'(ex);
    tick();
    we = 1'b0; re = 1'b0;
    m_base[b] = bs % 65536; m_len[b] = ln % 4096;
    m_sign[b] = sg & 1; m_exp[b] = ex % 8; m_off[b] = 0;
    exp_wrap = 0;
    check("cfg");
  endtask

  task automatic do_read(input int b);
    cbs = dag_sel_t'(b); re = 1'b1; we = 1'b0;
    base = ADDR_W'($urandom); len = LEN_W'($urandom);
    tick();
    re = 1'b0;
    model_read(b);
    check("read");
  endtask

  task automatic do_idle();
    tick();
    exp_wrap = 0;
    check("idle");
  endtask

  task automatic do_reset();
    reset = 1'b1; re = 1'b1; we = 1'b0;
    tick();
    reset = 1'b0; re = 1'b0;
    model_reset();
    check("reset");
    expect_a('0, "reset_a");
  endtask

  initial begin
    model_reset();
    tick();
    do_reset();

    do_cfg(0, 'hAB00, 8, 0, 1, 0);
    do_read(0); expect_a(16'hAB00, "c1_0");
    do_read(0); expect_a(16'hAB02, "c1_1");
    do_read(0); expect_a(16'hAB04, "c1_2");
    do_read(0); expect_a(16'hAB06, "c1_3");
`ifdef DAG_WRAP_FLAG_EN
    checks++;
    assert (wrap === 1'b1) else begin
      errors++;
      $error("FAIL c1_wrap: got %b expected 1", wrap);
    end
`endif
    do_read(0); expect_a(16'hAB00, "c1_4");

    do_cfg(1, 'h1000, 6, 1, 0, 0);
    do_read(1); expect_a(16'h1000, "c2_0");
    do_read(1); expect_a(16'h1005, "c2_1");
    do_read(1); expect_a(16'h1004, "c2_2");

    do_cfg(0, 'hAB00, 8, 0, 1, 0);
    do_cfg(2, 'h2000, 4, 0, 0, 0);
    do_read(0); expect_a(16'hAB00, "il_0");
    do_read(2); expect_a(16'h2000, "il_1");
    do_read(0); expect_a(16'hAB02, "il_2");
    do_idle();  expect_a(16'hAB02, "idle_hold");

    do_cfg(2, 'h3300, 5, 0, 2, 1); expect_a(16'hAB02, "wr_hold");
    do_read(2); expect_a(16'h3300, "wr_new");
    do_read(2); expect_a(16'h3304, "wr_adv");

    do_read(1); expect_a(16'h1003, "pre_rst");
    do_reset();
    do_read(3); expect_a(16'h0000, "len0_a");
    do_read(3); expect_a(16'h0000, "len0_b");

    do_cfg(4, 'hFFFE, 3, 0, 7, 0);
    do_read(4); expect_a(16'hFFFE, "big_s0");
    do_read(4); expect_a(16'hFFFE, "big_s1");

    for (int i = 0; i < 400; i++) begin
      int op, b;
      op = $urandom_range(0, 9);
      b = $urandom_range(0, NUM_BUF - 1);
      if (op == 0)
        do_cfg(b, $urandom_range(0, 65535),
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4095)
                                           : $urandom_range(0, 40),
               $urandom_range(0, 1), $urandom_range(0, 7),
               $urandom_range(0, 1) == 1);
      else if (op == 1)
        do_idle();
      else if (op == 2 && i % 97 == 5)
        do_reset();
      else
        do_read(b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
